ct_ifu_ind_btb_ctrl: RTL

//  Access controller for the single-port 256x23 indirect-BTB array.
//  - Shares the one SRAM port between IF-stage prediction reads and BJU/retire target updates.
//  - Buffers updates in a 2-entry write buffer and forwards buffered data to colliding reads.
//  - Sequences the invalidate-all sweep after reset and on request.
//  - Drives the array's CEN/GWEN/index/data and its gated-clock enable.

---
 rtl/ct_ifu_ind_btb_pkg.sv | 16 +
 rtl/ct_ifu_ind_btb_wbuf.sv | 93 +++++++++
 rtl/ct_ifu_ind_btb_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/ct_ifu_ind_btb_pkg.sv
// Shared widths, sizes and FSM encoding for the indirect-BTB access controller.
package ct_ifu_ind_btb_pkg;
  localparam int IDX_W  = 8;
  localparam int DATA_W = 23;
  localparam int DEPTH  = 256;
  localparam int WBUF_N = 2;
  localparam int CNT_W  = $clog2(WBUF_N + 1);

  localparam logic [IDX_W-1:0] SWEEP_LAST = IDX_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] WBUF_FULL  = CNT_W'(WBUF_N);

  typedef enum logic {
    INV  = 1'b0,
    IDLE = 1'b1
  } fsm_e;
endpackage

// File: rtl/ct_ifu_ind_btb_wbuf.sv
// Small in-order write buffer for indirect-BTB updates, with an index-match
// port that reports the youngest buffered data for a given index.
module ct_ifu_ind_btb_wbuf
  import ct_ifu_ind_btb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [IDX_W-1:0]  push_idx,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              flush,
  input  logic [IDX_W-1:0]  match_idx,
  output logic              match_hit,
  output logic [DATA_W-1:0] match_data,
  output logic [CNT_W-1:0]  count,
  output logic [IDX_W-1:0]  head_idx,
  output logic [DATA_W-1:0] head_data
);
  logic [IDX_W-1:0]  idx_q  [WBUF_N];
  logic [IDX_W-1:0]  idx_d  [WBUF_N];
  logic [DATA_W-1:0] data_q [WBUF_N];
  logic [DATA_W-1:0] data_d [WBUF_N];
  logic [CNT_W-1:0]  count_q, count_d, wr_pos;
  logic [WBUF_N-1:0] hit_vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      for (int i = 0; i < WBUF_N; i++) begin
        idx_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      for (int i = 0; i < WBUF_N; i++) begin
        idx_q[i]  <= idx_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

  // Slot 0 is always the oldest entry; a pop shifts the rest down.
  always_comb begin
    idx_d   = idx_q;
    data_d  = data_q;
    count_d = count_q;
    wr_pos  = count_q - CNT_W'(pop);
    if (flush) begin
      count_d = '0;
    end else begin
      if (pop) begin
        for (int i = 0; i < WBUF_N - 1; i++) begin
          idx_d[i]  = idx_q[i+1];
          data_d[i] = data_q[i+1];
        end
      end
      if (push) begin
        for (int i = 0; i < WBUF_N; i++) begin
          if (wr_pos == CNT_W'(i)) begin
            idx_d[i]  = push_idx;
            data_d[i] = push_data;
          end
        end
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // The head being written this cycle is already in the array next cycle.
  genvar gi;
  generate
    for (gi = 0; gi < WBUF_N; gi++) begin : g_match
      assign hit_vec[gi] = (CNT_W'(gi) < count_q) & ~((gi == 0) & pop) &
                           (idx_q[gi] == match_idx);
    end
  endgenerate

  always_comb begin
    match_hit  = 1'b0;
    match_data = '0;
    for (int i = 0; i < WBUF_N; i++) begin
      if (hit_vec[i]) begin
        match_hit  = 1'b1;
        match_data = data_q[i];
      end
    end
  end

  assign count     = count_q;
  assign head_idx  = idx_q[0];
  assign head_data = data_q[0];
endmodule

// File: rtl/ct_ifu_ind_btb_ctrl.sv
// Single-port indirect-BTB access controller: invalidate sweep, read/update
// arbitration through a write buffer, read forwarding and array port drive.
module ct_ifu_ind_btb_ctrl
  import ct_ifu_ind_btb_pkg::*;
(
  input  logic              forever_cpuclk,
  input  logic              cpurst_b,
  input  logic              inv_req,
  output logic              inv_busy,
  input  logic              rd_req,
  input  logic [IDX_W-1:0]  rd_index,
  output logic              rd_gnt,
  output logic              rd_data_vld,
  output logic [DATA_W-1:0] rd_data,
  input  logic              upd_vld,
  input  logic [IDX_W-1:0]  upd_index,
  input  logic [DATA_W-1:0] upd_data,
  output logic              upd_ready,
  output logic              ind_btb_cen_b,
  output logic              ind_btb_wen_b,
  output logic [IDX_W-1:0]  ind_btb_index,
  output logic [DATA_W-1:0] ind_btb_data_in,
  output logic              ind_btb_clk_en,
  input  logic [DATA_W-1:0] ind_btb_dout
);
  fsm_e              state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              rd_data_vld_q, rd_data_vld_d;
  logic              fwd_hit_q, fwd_hit_d;
  logic [DATA_W-1:0] fwd_data_q, fwd_data_d;

  logic              wb_push, wb_pop, wb_flush, wb_hit;
  logic [CNT_W-1:0]  wb_count;
  logic [IDX_W-1:0]  wb_head_idx;
  logic [DATA_W-1:0] wb_head_data, wb_hit_data;

  logic              arb_cen_b, arb_wen_b, wr_go;
  logic [IDX_W-1:0]  arb_index;
  logic [DATA_W-1:0] arb_data;

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q       <= INV;
      cnt_q         <= '0;
      rd_data_vld_q <= 1'b0;
      fwd_hit_q     <= 1'b0;
      fwd_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rd_data_vld_q <= rd_data_vld_d;
      fwd_hit_q     <= fwd_hit_d;
      fwd_data_q    <= fwd_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      INV: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SWEEP_LAST) state_d = IDLE;
      end
      IDLE: if (inv_req) state_d = INV;
      default: state_d = INV;
    endcase
  end

  // A full buffer takes the port ahead of reads so the drain always makes progress.
  always_comb begin
    rd_gnt    = 1'b0;
    wr_go     = 1'b0;
    arb_cen_b = 1'b1;
    arb_wen_b = 1'b1;
    arb_index = '0;
    arb_data  = '0;
    if (state_q == INV) begin
      arb_cen_b = 1'b0;
      arb_wen_b = 1'b0;
      arb_index = cnt_q;
    end else begin
      if (wb_count == WBUF_FULL)  wr_go  = 1'b1;
      else if (rd_req)            rd_gnt = 1'b1;
      else if (wb_count != '0)    wr_go  = 1'b1;
      if (wr_go) begin
        arb_cen_b = 1'b0;
        arb_wen_b = 1'b0;
        arb_index = wb_head_idx;
        arb_data  = wb_head_data;
      end else if (rd_gnt) begin
        arb_cen_b = 1'b0;
        arb_index = rd_index;
      end
    end
  end

  always_comb begin
    rd_data_vld_d = rd_gnt;
    fwd_hit_d     = rd_gnt & wb_hit;
    fwd_data_d    = rd_gnt ? wb_hit_data : fwd_data_q;
  end

  assign upd_ready = (wb_count != WBUF_FULL) & (state_q == IDLE);
  assign wb_push   = upd_vld & upd_ready;
  assign wb_pop    = wr_go;
  assign wb_flush  = (state_q == IDLE) & inv_req;

  ct_ifu_ind_btb_wbuf u_wbuf (
    .clk        (forever_cpuclk),
    .rst_n      (cpurst_b),
    .push       (wb_push),
    .push_idx   (upd_index),
    .push_data  (upd_data),
    .pop        (wb_pop),
    .flush      (wb_flush),
    .match_idx  (rd_index),
    .match_hit  (wb_hit),
    .match_data (wb_hit_data),
    .count      (wb_count),
    .head_idx   (wb_head_idx),
    .head_data  (wb_head_data)
  );

  // The array stays deselected while reset is held, even though the FSM already sits in INV.
  assign ind_btb_cen_b   = arb_cen_b | ~cpurst_b;
  assign ind_btb_wen_b   = arb_wen_b | ~cpurst_b;
  assign ind_btb_index   = arb_index;
  assign ind_btb_data_in = arb_data;
  assign ind_btb_clk_en  = ~ind_btb_cen_b;
  assign inv_busy        = (state_q == INV);
  assign rd_data_vld     = rd_data_vld_q;
  assign rd_data         = rd_data_vld_q ? (fwd_hit_q ? fwd_data_q : ind_btb_dout) : '0;
endmodule
